// File: rtl/cdb_complete_arbiter_pkg.sv
// Shared completion-side types: FU result packets, CDB tag packet and the FU state vector.
// Also holds the FU index constants and the vector-to-state mapping.
package cdb_complete_arbiter_pkg;

  localparam int NUM_FU = 8;
  localparam int CDBW   = 3;
  localparam int PRW    = 6;
  localparam int XLEN   = 32;
  localparam int PTRW   = $clog2(NUM_FU);

  localparam int ALU_1_IDX       = 0;
  localparam int ALU_2_IDX       = 1;
  localparam int ALU_3_IDX       = 2;
  localparam int STORELOAD_1_IDX = 3;
  localparam int STORELOAD_2_IDX = 4;
  localparam int MULT_1_IDX      = 5;
  localparam int MULT_2_IDX      = 6;
  localparam int BRANCH_IDX      = 7;

  typedef struct packed {
    logic [PRW-1:0]  dest_pr;
    logic [XLEN-1:0] value;
  } FU_COMPLETE_PACKET;

  typedef struct packed {
    logic [PRW-1:0] t0;
    logic [PRW-1:0] t1;
    logic [PRW-1:0] t2;
  } CDB_T_PACKET;

  typedef struct packed {
    logic branch;
    logic mult_2;
    logic mult_1;
    logic storeload_2;
    logic storeload_1;
    logic alu_3;
    logic alu_2;
    logic alu_1;
  } FU_STATE_PACKET;

  function automatic FU_STATE_PACKET fu_vec_to_state(input logic [NUM_FU-1:0] vec);
    FU_STATE_PACKET s;
    s.alu_1       = vec[ALU_1_IDX];
    s.alu_2       = vec[ALU_2_IDX];
    s.alu_3       = vec[ALU_3_IDX];
    s.storeload_1 = vec[STORELOAD_1_IDX];
    s.storeload_2 = vec[STORELOAD_2_IDX];
    s.mult_1      = vec[MULT_1_IDX];
    s.mult_2      = vec[MULT_2_IDX];
    s.branch      = vec[BRANCH_IDX];
    return s;
  endfunction

endpackage

// File: rtl/cdb_complete_arbiter_rr_pick3.sv
// Combinational round-robin picker: grants up to CDBW requests in scan order starting at ptr.
// Lane k receives the (k+1)-th request found; next_ptr points just past the last grant.
module rr_pick3
  import cdb_complete_arbiter_pkg::*;
(
  input  logic [NUM_FU-1:0]            req,
  input  logic [PTRW-1:0]              ptr,
  output logic [CDBW-1:0][NUM_FU-1:0]  lane_grant,
  output logic [PTRW-1:0]              next_ptr
);

  always_comb begin
    logic [PTRW-1:0] idx;
    logic [1:0]      cnt;
    lane_grant = '0;
    next_ptr   = ptr;
    idx        = '0;
    cnt        = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = ptr + PTRW'(k);
      if (req[idx] && (cnt < 2'(CDBW))) begin
        lane_grant[cnt][idx] = 1'b1;
        next_ptr             = idx + PTRW'(1);
        cnt                  = cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/cdb_complete_arbiter.sv
// Buffers one completed result per FU and broadcasts up to three tags per cycle on the CDB.
// fu_ready lets the RS re-issue to a unit only when its buffer is free or draining this cycle.
module cdb_complete_arbiter
  import cdb_complete_arbiter_pkg::*;
(
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   squash,
  input  logic [NUM_FU-1:0]                      fu_done,
  input  FU_COMPLETE_PACKET [NUM_FU-1:0]         fu_result,
  input  logic [NUM_FU-1:0]                      fu_busy,
  output FU_STATE_PACKET                         fu_ready,
  output CDB_T_PACKET                            cdb_t,
  output logic [CDBW-1:0][XLEN-1:0]              wb_value,
  output logic [CDBW-1:0]                        wb_valid
);

  logic [NUM_FU-1:0]             buf_valid;
  logic [NUM_FU-1:0][PRW-1:0]    buf_pr;
  logic [NUM_FU-1:0][XLEN-1:0]   buf_value;
  logic [PTRW-1:0]               rr_ptr;
  logic [PTRW-1:0]               next_ptr;
  logic [NUM_FU-1:0]             req;
  logic [NUM_FU-1:0]             grant;
  logic [CDBW-1:0][NUM_FU-1:0]   lane_grant;
  logic [CDBW-1:0][PRW-1:0]      lane_tag;

  // Squash masks the requests so no grant (and no lane) is produced that cycle.
  assign req = squash ? '0 : buf_valid;

  rr_pick3 u_pick (
    .req        (req),
    .ptr        (rr_ptr),
    .lane_grant (lane_grant),
    .next_ptr   (next_ptr)
  );

  always_comb begin
    grant = '0;
    for (int l = 0; l < CDBW; l++) begin
      grant = grant | lane_grant[l];
    end
  end

  // Lane grants are one-hot, so an AND-OR mux selects each lane's buffer.
  always_comb begin
    lane_tag = '0;
    wb_value = '0;
    wb_valid = '0;
    for (int l = 0; l < CDBW; l++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (lane_grant[l][i]) begin
          lane_tag[l] = lane_tag[l] | buf_pr[i];
          wb_value[l] = wb_value[l] | buf_value[i];
          wb_valid[l] = 1'b1;
        end
      end
    end
    cdb_t.t0 = lane_tag[0];
    cdb_t.t1 = lane_tag[1];
    cdb_t.t2 = lane_tag[2];
  end

  assign fu_ready = fu_vec_to_state(~fu_busy & (~buf_valid | grant));

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid <= '0;
      buf_pr    <= '0;
      buf_value <= '0;
      rr_ptr    <= '0;
    end else if (squash) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
    end else begin
      rr_ptr <= next_ptr;
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_done[i] && (fu_result[i].dest_pr != '0)) begin
          buf_valid[i] <= 1'b1;
          buf_pr[i]    <= fu_result[i].dest_pr;
          buf_value[i] <= fu_result[i].value;
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // A unit must not complete into its buffer while an older result there is still waiting.
  no_overwrite_pending: assert property (@(posedge clock) disable iff (reset || squash)
    (fu_done & buf_valid & ~grant) == '0);

endmodule
